// File: rtl/memory_ctrl_if.sv
// -----------------------------------------------------------------------------
// memory_ctrl_if
// Command-side handshake bundle between a requester and memory_ctrl.
//
// Signals:
//   cmd_valid  requester has a command pending
//   cmd_ready  controller idle; command taken when cmd_valid & cmd_ready
//   cmd_op     00 write, 01 read, 10 shift, 11 illegal
//   cmd_addr   target memory address
//   cmd_wdata  write data
//   cmd_sd     shift direction (shift op only)
//   cmd_sv     shift fill value (shift op only)
//   done       one-cycle completion pulse
//   rdata      last read result, held until the next read completes
//   err_out    error status of the last completed op, held until next done
//
// Modports:
//   master  requester side (drives the command, observes status)
//   slave   controller side
// -----------------------------------------------------------------------------
interface memory_ctrl_if #(
    parameter int Addr_width = 3,
    parameter int Data_width = 8
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [Addr_width-1:0] cmd_addr;
    logic [Data_width-1:0] cmd_wdata;
    logic                  cmd_sd;
    logic                  cmd_sv;
    logic                  done;
    logic [Data_width-1:0] rdata;
    logic                  err_out;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_wdata,
        output cmd_sd,
        output cmd_sv,
        input  cmd_ready,
        input  done,
        input  rdata,
        input  err_out
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_wdata,
        input  cmd_sd,
        input  cmd_sv,
        output cmd_ready,
        output done,
        output rdata,
        output err_out
    );

endinterface

// File: rtl/memory_ctrl.sv
// -----------------------------------------------------------------------------
// memory_ctrl
// Sequences one memory command at a time through a fixed four-state strobe
// protocol (IDLE -> SETUP -> STROBE -> HOLD -> IDLE). Every output is a
// register, so the memory sees clean, glitch-free strobes.
//
// Timing for a legal op accepted at edge N:
//   cycle N+1  SETUP   cs=1, addr valid, no strobe
//   cycle N+2  STROBE  cs=1, exactly one of pw/pr/ps
//   cycle N+3  HOLD    cs=1, strobes low, done=1
//   cycle N+4  IDLE    ready for the next command
// An illegal op (11) goes straight to HOLD with cs low, reporting done and
// err_out=1 in cycle N+1.
//
// Ports:
//   clk_i    single clock, rising edge
//   rst_i    synchronous, active-high reset
//   cmd      command handshake (memory_ctrl_if.slave)
//   cs_o     memory chip select
//   pw_o     write strobe
//   pr_o     read strobe
//   ps_o     shift strobe
//   sd_o     shift direction (valid only during a shift op)
//   sv_o     shift fill value (valid only during a shift op)
//   addr_o   memory address (0 while idle)
//   data_io  shared bidirectional memory data bus
//   err_i    memory error flag, sampled on the edge leaving STROBE
// -----------------------------------------------------------------------------
module memory_ctrl #(
    parameter int Addr_width = 3,
    parameter int Data_width = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    memory_ctrl_if.slave          cmd,
    output logic                  cs_o,
    output logic                  pw_o,
    output logic                  pr_o,
    output logic                  ps_o,
    output logic                  sd_o,
    output logic                  sv_o,
    output logic [Addr_width-1:0] addr_o,
    inout  wire  [Data_width-1:0] data_io,
    input  logic                  err_i
);

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_SHIFT   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_STROBE = 2'b10,
        S_HOLD   = 2'b11
    } state_e;

    // Controller state and registered outputs.
    state_e                state_q;
    logic                  ready_q;
    logic                  done_q;
    logic [Data_width-1:0] rdata_q;
    logic                  err_out_q;
    logic                  cs_q;
    logic                  pw_q;
    logic                  pr_q;
    logic                  ps_q;
    logic                  sd_q;
    logic                  sv_q;
    logic [Addr_width-1:0] addr_q;
    logic                  data_oe_q;

    // Command fields captured at accept. They are only consumed outside
    // IDLE, after having been loaded, so they carry no reset.
    op_e                   op_q;
    logic [Data_width-1:0] wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Aborts any operation in flight; no done is produced.
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            err_out_q <= 1'b0;
            cs_q      <= 1'b0;
            pw_q      <= 1'b0;
            pr_q      <= 1'b0;
            ps_q      <= 1'b0;
            sd_q      <= 1'b0;
            sv_q      <= 1'b0;
            addr_q    <= '0;
            data_oe_q <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless a state below raises it.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // ready_q is always 1 here, so valid alone means accept.
                    if (cmd.cmd_valid) begin
                        op_q    <= op_e'(cmd.cmd_op);
                        wdata_q <= cmd.cmd_wdata;
                        ready_q <= 1'b0;
                        if (op_e'(cmd.cmd_op) == OP_ILLEGAL) begin
                            // No memory activity at all: report and leave.
                            state_q   <= S_HOLD;
                            done_q    <= 1'b1;
                            err_out_q <= 1'b1;
                        end else begin
                            state_q   <= S_SETUP;
                            cs_q      <= 1'b1;
                            addr_q    <= cmd.cmd_addr;
                            data_oe_q <= (op_e'(cmd.cmd_op) == OP_WRITE);
                            // sd/sv stay low for anything but a shift.
                            sd_q      <= (op_e'(cmd.cmd_op) == OP_SHIFT) & cmd.cmd_sd;
                            sv_q      <= (op_e'(cmd.cmd_op) == OP_SHIFT) & cmd.cmd_sv;
                        end
                    end
                end

                S_SETUP: begin
                    state_q <= S_STROBE;
                    pw_q    <= (op_q == OP_WRITE);
                    pr_q    <= (op_q == OP_READ);
                    ps_q    <= (op_q == OP_SHIFT);
                end

                S_STROBE: begin
                    // The memory has had the whole strobe cycle to respond,
                    // so data and error are captured on the way out.
                    state_q   <= S_HOLD;
                    pw_q      <= 1'b0;
                    pr_q      <= 1'b0;
                    ps_q      <= 1'b0;
                    done_q    <= 1'b1;
                    err_out_q <= err_i;
                    if (op_q == OP_READ) begin
                        rdata_q <= data_io;
                    end
                end

                S_HOLD: begin
                    // Shared exit for legal ops and the illegal shortcut;
                    // the clears below are no-ops on the illegal path.
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    cs_q      <= 1'b0;
                    addr_q    <= '0;
                    data_oe_q <= 1'b0;
                    sd_q      <= 1'b0;
                    sv_q      <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // The controller only ever drives the bus for a write, from SETUP
    // through HOLD; otherwise it leaves the bus to the memory.
    assign data_io = data_oe_q ? wdata_q : {Data_width{1'bz}};

    assign cmd.cmd_ready = ready_q;
    assign cmd.done      = done_q;
    assign cmd.rdata     = rdata_q;
    assign cmd.err_out   = err_out_q;

    assign cs_o   = cs_q;
    assign pw_o   = pw_q;
    assign pr_o   = pr_q;
    assign ps_o   = ps_q;
    assign sd_o   = sd_q;
    assign sv_o   = sv_q;
    assign addr_o = addr_q;

endmodule

// File: doc/memory_ctrl.md
MEMORY_CTRL -- requirements
Module: memory_ctrl

Interface
REQ-001 Parameter Addr_width, default 3, memory address width in bits.
REQ-002 Parameter Data_width, default 8, memory data width in bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  controller idle, command accepted when CMD_VALID & CMD_READY.
REQ-007 CMD_OP  input  2  00 write, 01 read, 10 shift, 11 illegal.
REQ-008 CMD_ADDR  input  Addr_width  target address.
REQ-009 CMD_WDATA  input  Data_width  write data.
REQ-010 CMD_SD  input  1  shift direction for shift op.
REQ-011 CMD_SV  input  1  shift fill value for shift op.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 RDATA  output  Data_width  read result, held until next read completes.
REQ-014 ERR_OUT  output  1  error status of last completed op, held until next DONE.
REQ-015 CS, PW, PR, PS, SD, SV  output  1 each  memory chip-select, write, read and shift strobes, shift direction and value.
REQ-016 ADDR  output  Addr_width  memory address.
REQ-017 DATA  inout  Data_width  shared memory data bus.
REQ-018 ERR  input  1  memory error flag.

Function
REQ-019 States SHALL be IDLE, SETUP, STROBE, HOLD, and IDLE SHALL be the only state with CMD_READY=1.
REQ-020 On accept in IDLE (edge N), the controller SHALL latch op, address, wdata, SD and SV, and enter SETUP (or HOLD for op 11).
REQ-021 SETUP (cycle N+1) SHALL drive CS=1 and ADDR=latched address, with all strobes 0.
REQ-022 STROBE (cycle N+2) SHALL keep CS=1 and assert exactly one of PW/PR/PS for one cycle per op.
REQ-023 HOLD (cycle N+3) SHALL keep CS=1 and ADDR, deassert all strobes, pulse DONE=1, then return to IDLE.
REQ-024 A legal op SHALL have latency from accept edge to DONE of 3 cycles, and the next accept SHALL be possible at cycle N+4 earliest.
REQ-025 Write: DATA SHALL be driven with latched wdata in SETUP, STROBE and HOLD, and SHALL be high-impedance in every other state and every non-write op.
REQ-026 Read: DATA SHALL never be driven by the controller, and RDATA SHALL capture DATA on the edge leaving STROBE.
REQ-027 Shift: SD/SV SHALL equal latched values in SETUP, STROBE and HOLD, and SHALL be 0 otherwise.
REQ-028 ERR SHALL be sampled on the edge leaving STROBE, and ERR_OUT SHALL take that value coincident with DONE.
REQ-029 Illegal op 11: no CS or strobe activity; HOLD with CS=0, DONE=1 and ERR_OUT=1 at cycle N+1; then IDLE.
REQ-030 CMD_VALID while not IDLE SHALL be ignored, and command inputs SHALL have no effect after latching.
REQ-031 In IDLE, CS, PW, PR, PS, SD and SV SHALL be 0, ADDR SHALL be 0, and DATA SHALL be high-impedance.
REQ-032 RDATA SHALL be unchanged by write, shift and illegal ops.

Reset
REQ-033 While RST=1 at an edge: state IDLE, CMD_READY=1, DONE=0, RDATA=0, ERR_OUT=0, all memory strobes/CS/SD/SV/ADDR=0, DATA high-impedance.
REQ-034 RST in any state mid-operation SHALL abort without DONE, with outputs per REQ-033 from the next edge.
REQ-035 RST SHALL take priority over a simultaneous CMD_VALID, and the command SHALL be dropped.

Verification
REQ-036 Write: op 00, addr 001, wdata 00001111 -> CS=1 cycles N+1..N+3, PW=1 only N+2, DATA=00001111 N+1..N+3 else Z, DONE at N+3, ERR_OUT=0.
REQ-037 Read: memory model returns 10100101 at addr 001 -> PR=1 only N+2, DATA never driven by DUT, RDATA=10100101 with DONE at N+3.
REQ-038 Shift: op 10, SD=1, SV=1, addr 001 -> PS=1 only N+2, SD=SV=1 N+1..N+3 and 0 after, RDATA unchanged.
REQ-039 Error and illegal: ERR=1 during STROBE of a read -> ERR_OUT=1 at DONE; op 11 -> DONE and ERR_OUT=1 at N+1, CS never asserted.
REQ-040 Back-to-back and reset: CMD_VALID held high gives accepts 4 cycles apart; RST at N+2 of a write -> no DONE, PW=0 and DATA=Z next edge, CMD_READY=1.
